// File: rtl/icache_direct.sv
`default_nettype none
// ============================================================================
// Module      : icache_direct
// Description : Direct-mapped, one-word-per-frame read-only instruction cache
//               with miss fill through the memory controller's instruction
//               port and saturating hit/miss statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_direct #(
  parameter int SETS = 16,
  parameter int CNTW = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            imemREN,
  input  logic [31:0]     imemaddr,
  output logic            ihit,
  output logic [31:0]     imemload,
  output logic            iREN,
  output logic [31:0]     iaddr,
  input  logic            iwait,
  input  logic [31:0]     iload,
  input  logic            flush,
  output logic [CNTW-1:0] hitcnt,
  output logic [CNTW-1:0] misscnt
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;

  localparam logic [0:0] c_IDLE  = 1'b0;
  localparam logic [0:0] c_FETCH = 1'b1;

  localparam logic [CNTW-1:0] c_CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  logic [0:0]      r_state;
  logic [31:0]     r_missaddr;
  logic [SETS-1:0] r_valid;
  logic [TW-1:0]   r_tag  [SETS];
  logic [31:0]     r_data [SETS];
  logic [CNTW-1:0] r_hitcnt;
  logic [CNTW-1:0] r_misscnt;

  logic [IW-1:0] w_idx;
  logic [TW-1:0] w_tag;
  logic [IW-1:0] w_fidx;
  logic [TW-1:0] w_ftag;
  logic          w_idle;
  logic          w_hit;
  logic          w_miss;
  logic          w_fill;
  logic          w_unused_lo;

  assign w_idx       = imemaddr[IW+1:2];
  assign w_tag       = imemaddr[31:IW+2];
  assign w_fidx      = r_missaddr[IW+1:2];
  assign w_ftag      = r_missaddr[31:IW+2];
  assign w_unused_lo = ^imemaddr[1:0];

  assign w_idle = (r_state == c_IDLE);
  assign w_hit  = w_idle & imemREN & r_valid[w_idx] & (r_tag[w_idx] == w_tag) & ~flush;
  assign w_miss = w_idle & imemREN & ~w_hit & ~flush;
  assign w_fill = (r_state == c_FETCH) & ~iwait;

  assign ihit     = w_hit;
  assign imemload = w_hit ? r_data[w_idx] : 32'h0;
  // Request signals decode only registered state so they never follow imemaddr.
  assign iREN     = (r_state == c_FETCH);
  assign iaddr    = (r_state == c_FETCH) ? r_missaddr : 32'h0;
  assign hitcnt   = r_hitcnt;
  assign misscnt  = r_misscnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= c_IDLE;
      r_missaddr <= 32'h0;
      r_valid    <= '0;
      r_hitcnt   <= '0;
      r_misscnt  <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_miss) begin
            r_missaddr <= {imemaddr[31:2], 2'b00};
            r_state    <= c_FETCH;
          end
        end
        c_FETCH: begin
          if (!iwait) r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase

      // Flush beats a same-edge fill, leaving the filled frame invalid.
      if (flush)       r_valid         <= '0;
      else if (w_fill) r_valid[w_fidx] <= 1'b1;

      if (w_hit && (r_hitcnt != {CNTW{1'b1}}))
        r_hitcnt <= r_hitcnt + c_CNT_ONE;
      if (w_miss && (r_misscnt != {CNTW{1'b1}}))
        r_misscnt <= r_misscnt + c_CNT_ONE;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && w_fill) begin
      r_tag[w_fidx]  <= w_ftag;
      r_data[w_fidx] <= iload;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_icache_direct.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_direct
// Description : Directed self-checking bench for icache_direct.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_direct;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        flush;

  logic        ihit, iREN;
  logic [31:0] imemload, iaddr;
  logic [15:0] hitcnt, misscnt;

  logic        ihit4, iREN4;
  logic [31:0] imemload4, iaddr4;
  logic [3:0]  hitcnt4, misscnt4;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  icache_direct #(.SETS(16), .CNTW(16)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
    .iwait(iwait), .iload(iload), .flush(flush),
    .hitcnt(hitcnt), .misscnt(misscnt)
  );

  icache_direct #(.SETS(16), .CNTW(4)) dut4 (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit4), .imemload(imemload4), .iREN(iREN4), .iaddr(iaddr4),
    .iwait(iwait), .iload(iload), .flush(flush),
    .hitcnt(hitcnt4), .misscnt(misscnt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Present a missing address, then run the fetch with 'waits' busy cycles.
  task automatic miss_fill(input logic [31:0] a, input int waits, input logic [31:0] d);
    imemREN  = 1'b1;
    imemaddr = a;
    iwait    = 1'b1;
    flush    = 1'b0;
    #1 chk("miss_ihit", {31'b0, ihit}, 32'd0);
    cyc();
    for (int i = 0; i <= waits; i++) begin
      iwait = (i < waits);
      iload = (i < waits) ? 32'hDEAD_BEEF : d;
      #1;
      chk("fill_iren", {31'b0, iREN}, 32'd1);
      chk("fill_iaddr", iaddr, {a[31:2], 2'b00});
      chk("fill_ihit", {31'b0, ihit}, 32'd0);
      cyc();
    end
    iwait = 1'b1;
  endtask

  task automatic expect_hit(input logic [31:0] a, input logic [31:0] d);
    imemREN  = 1'b1;
    imemaddr = a;
    #1;
    chk("hit_ihit", {31'b0, ihit}, 32'd1);
    chk("hit_data", imemload, d);
    chk("hit_iren", {31'b0, iREN}, 32'd0);
    cyc();
  endtask

  initial begin
    RST = 1'b1; imemREN = 1'b0; imemaddr = 32'h0;
    iwait = 1'b1; iload = 32'h0; flush = 1'b0;
    cyc(); cyc();
    RST = 1'b0;
    #1;
    chk("rst_ihit", {31'b0, ihit}, 32'd0);
    chk("rst_imemload", imemload, 32'd0);
    chk("rst_iren", {31'b0, iREN}, 32'd0);
    chk("rst_iaddr", iaddr, 32'd0);
    chk("rst_hitcnt", {16'b0, hitcnt}, 32'd0);
    chk("rst_misscnt", {16'b0, misscnt}, 32'd0);
    cyc();

    // Cold miss: four FETCH cycles, then a hit on the re-presented request
    miss_fill(32'h40, 3, 32'h2108_0001);
    #1 chk("cold_misscnt", {16'b0, misscnt}, 32'd1);
    chk("cold_hitcnt", {16'b0, hitcnt}, 32'd0);
    for (int i = 0; i < 5; i++) expect_hit(32'h40, 32'h2108_0001);
    expect_hit(32'h42, 32'h2108_0001);
    imemREN = 1'b0;
    #1 chk("hit_hitcnt", {16'b0, hitcnt}, 32'd6);
    cyc();

    // Conflict on index 0
    miss_fill(32'h440, 0, 32'hAAAA_0440);
    expect_hit(32'h440, 32'hAAAA_0440);
    miss_fill(32'h40, 1, 32'h2108_0001);
    expect_hit(32'h40, 32'h2108_0001);
    imemREN = 1'b0;
    #1 chk("conf_misscnt", {16'b0, misscnt}, 32'd3);
    cyc();

    // Redirect mid-fill
    imemREN = 1'b1; imemaddr = 32'h80; iwait = 1'b1;
    #1 chk("redir_miss", {31'b0, ihit}, 32'd0);
    cyc();
    imemaddr = 32'h100;
    for (int i = 0; i < 3; i++) begin
      iwait = (i < 2);
      iload = 32'h8080_8080;
      #1 chk("redir_iaddr", iaddr, 32'h80);
      cyc();
    end
    iwait = 1'b1;
    expect_hit(32'h80, 32'h8080_8080);
    miss_fill(32'h100, 0, 32'h0100_0100);
    expect_hit(32'h100, 32'h0100_0100);

    // Flush in IDLE
    miss_fill(32'h40, 0, 32'h2108_0001);
    expect_hit(32'h40, 32'h2108_0001);
    imemREN = 1'b1; imemaddr = 32'h40; flush = 1'b1;
    #1 chk("flush_ihit", {31'b0, ihit}, 32'd0);
    cyc();
    flush = 1'b0;
    miss_fill(32'h40, 0, 32'h2108_0001);
    expect_hit(32'h40, 32'h2108_0001);

    // Flush on the final FETCH cycle
    imemREN = 1'b1; imemaddr = 32'h44; iwait = 1'b1;
    #1 chk("ff_miss", {31'b0, ihit}, 32'd0);
    cyc();
    iwait = 1'b0; iload = 32'h4444_4444; flush = 1'b1;
    #1 chk("ff_iren", {31'b0, iREN}, 32'd1);
    cyc();
    flush = 1'b0; iwait = 1'b1;
    miss_fill(32'h44, 0, 32'h4444_4444);
    expect_hit(32'h44, 32'h4444_4444);
    imemREN = 1'b0;
    #1;
    chk("ff_misscnt", {16'b0, misscnt}, 32'd9);
    chk("ff_hitcnt", {16'b0, hitcnt}, 32'd13);
    cyc();

    // Reset during FETCH
    imemREN = 1'b1; imemaddr = 32'h48; iwait = 1'b1;
    #1 chk("rf_miss", {31'b0, ihit}, 32'd0);
    cyc();
    #1 chk("rf_iren_pre", {31'b0, iREN}, 32'd1);
    RST = 1'b1; iload = 32'h4848_4848;
    cyc();
    RST = 1'b0; imemREN = 1'b0;
    #1;
    chk("rf_iren", {31'b0, iREN}, 32'd0);
    chk("rf_iaddr", iaddr, 32'd0);
    chk("rf_misscnt", {16'b0, misscnt}, 32'd0);
    chk("rf_hitcnt", {16'b0, hitcnt}, 32'd0);
    cyc();
    miss_fill(32'h48, 0, 32'h4848_4848);

    // Saturation
    for (int i = 0; i < 20; i++) expect_hit(32'h48, 32'h4848_4848);
    imemREN = 1'b0;
    #1;
    chk("sat_hitcnt16", {16'b0, hitcnt}, 32'd20);
    chk("sat_hitcnt4", {28'b0, hitcnt4}, 32'd15);
    chk("sat_misscnt4", {28'b0, misscnt4}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/icache_direct.md
# icache_direct

Direct-mapped, read-only instruction cache answering the pipeline's fetch requests. The fetch stage drives `imemREN`/`imemaddr`. This block returns `ihit`/`imemload` from a 16-frame, one-word-per-frame store. On a miss it fetches the word through the memory controller's instruction port, which uses `iREN`/`iaddr`/`iwait`/`iload`. It sits between the datapath fetch logic and the memory controller, and also keeps saturating hit/miss counters for end-of-run statistics.

## Interface

Parameters:

- `SETS`, default 16: number of frames. Must be a power of two, minimum 2.
- `CNTW`, default 16: width of the hit/miss counters.

Ports (all synchronous to `CLK`):

- `CLK` in 1: clock, rising edge.
- `RST` in 1: reset. Synchronous, active-high.
- `imemREN` in 1: fetch request valid.
- `imemaddr` in 32: fetch byte address. Bits [1:0] are ignored.
- `ihit` out 1: requested word is valid on `imemload` this cycle.
- `imemload` out 32: instruction word. Zero when `ihit`=0.
- `iREN` out 1: memory read request.
- `iaddr` out 32: memory read address, word-aligned.
- `iwait` in 1: memory busy. Low means `iload` is valid this cycle.
- `iload` in 32: memory read data.
- `flush` in 1: invalidate all frames.
- `hitcnt` out CNTW: number of hits, saturating.
- `misscnt` out CNTW: number of misses, saturating.

## Operation

Address split, with IW = log2(SETS):

- index = `imemaddr[IW+1:2]`
- tag = `imemaddr[31:IW+2]`

Each frame holds `valid`, `tag` and a 32-bit `data` word.

State machine:

- **IDLE**
  - hit = `imemREN` & `valid[index]` & (`tag[index]` == tag) & !`flush`.
  - `ihit` = hit, combinational. `imemload` = `data[index]` when hit, else 0.
  - `imemREN` & !hit & !`flush` is a miss:
    - latch `missaddr` = {`imemaddr[31:2]`, 2'b00};
    - go to FETCH;
    - increment `misscnt`.
  - Each cycle with hit=1 increments `hitcnt` (once per cycle hit is high).
- **FETCH**
  - `iREN`=1, `iaddr`=`missaddr`, `ihit`=0.
  - When `iwait`=0: at the same edge write the frame at `missaddr`'s index (`valid`=1, tag, `data`=`iload`), then go to IDLE.
  - While `iwait`=1: stay in FETCH.

Common rules:

- `iREN`=0 and `iaddr`=0 in IDLE.
- A fill always completes once issued, even if `imemREN` drops or `imemaddr` changes (branch redirect). The memory controller cannot abort a request. The filled word is retained.
- `flush`: every `valid` bit clears at the next edge. In IDLE it also forces `ihit`=0 combinationally.
  - Flush in FETCH: the fill still completes the handshake and returns to IDLE, but flush wins, so the frame is left invalid.
- Counters saturate at all-ones and do not wrap. They are cleared only by `RST`.
- Frame replacement is by index only. A new tag overwrites the old one unconditionally.

## Timing

- Reset: state=IDLE, all `valid`=0. All outputs are 0: `ihit`, `imemload`, `iREN`, `iaddr`, `hitcnt`, `misscnt`.
- Tag and data arrays need not be reset.
- `RST` during FETCH abandons the fill: state goes to IDLE and no frame is written. `RST` has priority over `flush` and the fill.
- Hit latency: 0 cycles. `ihit` goes high in the same cycle as `imemREN`.
- Miss latency, with the miss seen in cycle t:
  - FETCH during t+1..t+k, where k is the number of FETCH cycles up to and including the first cycle with `iwait`=0;
  - fill at the end of t+k;
  - the re-presented request hits in t+k+1.
  - Minimum is k=1, so `ihit` arrives in cycle t+2.
- `iREN`/`iaddr` are registered-state decodes: stable for the whole FETCH and glitch-free with respect to `imemaddr`.

## Test plan

- **Reset, cold miss:** `RST`=1 for 2 cycles, then `imemREN`=1, `imemaddr`=0x0000_0040, memory `iwait`=1 for 3 cycles then `iload`=0x2108_0001 → `iREN` high for exactly 4 cycles with `iaddr`=0x40; `ihit`=1 with `imemload`=0x2108_0001 in the following cycle; `misscnt`=1.
- **Hit:** re-read 0x40 for 5 cycles, and also read 0x42 (low bits ignored) → `ihit`=1 every cycle, `iREN`=0, `hitcnt` advances by 6.
- **Conflict:** fill 0x40, then 0x440 (same index, different tag), then 0x40 → three misses; the last fill restores 0x40's data; `misscnt`=3.
- **Redirect mid-fill:** miss on 0x80 with `iwait`=1 for 2 cycles, and `imemaddr` changed to 0x100 during FETCH → `iaddr` stays 0x80; frame for 0x80 becomes valid; 0x100 then misses.
- **Flush:**
  - after filling 0x40, pulse `flush` → next read of 0x40 misses;
  - `flush` during the final FETCH cycle → fill completes, frame left invalid.
- **Reset mid-fill and saturation:**
  - `RST` during FETCH → `iREN`=0 next cycle and the frame stays invalid;
  - with `CNTW`=4, 20 hits → `hitcnt`=15.
